// File: rtl/bsg_fpu_class_gen.sv
// bsg_fpu_class_gen: expands an fclass-style mask into canonical FP16 values,
// emitted serially lowest class bit first over a valid/yumi handshake.
module bsg_fpu_class_gen (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_i,
  input  logic [15:0] class_i,
  output logic        ready_o,
  output logic        v_o,
  output logic [15:0] z_o,
  output logic [15:0] class_o,
  output logic        last_o,
  input  logic        yumi_i
);

  logic [9:0] pend_r;
  logic [9:0] low;

  // isolate the lowest pending class bit
  assign low = pend_r & (~pend_r + 10'd1);

  assign ready_o = (pend_r == 10'd0);
  assign v_o     = (pend_r != 10'd0);
  assign class_o = {6'd0, low};
  assign last_o  = v_o & ((pend_r & (pend_r - 10'd1)) == 10'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_r <= 10'd0;
    end else if (v_i & ready_o) begin
      pend_r <= class_i[9:0];
    end else if (yumi_i & v_o) begin
      pend_r <= pend_r & ~low;
    end
  end

  always_comb begin
    z_o = 16'h0000;
    unique case (1'b1)
      low[0]:  z_o = 16'hFC00;
      low[1]:  z_o = 16'hBC00;
      low[2]:  z_o = 16'h8001;
      low[3]:  z_o = 16'h8000;
      low[4]:  z_o = 16'h0000;
      low[5]:  z_o = 16'h0001;
      low[6]:  z_o = 16'h3C00;
      low[7]:  z_o = 16'h7C00;
      low[8]:  z_o = 16'h7C01;
      low[9]:  z_o = 16'h7E00;
      default: z_o = 16'h0000;
    endcase
  end

endmodule

// File: doc/bsg_fpu_class_gen.md
BSG_FPU_CLASS_GEN -- requirements
Module: bsg_fpu_class_gen

Purpose: inverse of FP16 (e=5, m=10) classification. Takes a 10-bit RISC-V-style class mask and emits one canonical half-precision value per set class bit, serially, lowest bit first.

Interface
- REQ-001: clk_i  input  1  clock; all state updates on its rising edge.
- REQ-002: reset_i  input  1  reset; asynchronous, active-high.
- REQ-003: v_i  input  1  class mask valid.
- REQ-004: class_i  input  16  class mask; bits 9:0 used (fclass order), bits 15:10 ignored.
- REQ-005: ready_o  output  1  block can accept a mask.
- REQ-006: v_o  output  1  output value valid.
- REQ-007: z_o  output  16  canonical FP16 value for the current class.
- REQ-008: class_o  output  16  one-hot class of z_o; bits 15:10 always 0.
- REQ-009: last_o  output  1  z_o is the final value for the accepted mask.
- REQ-010: yumi_i  input  1  consumer takes z_o this cycle; legal only while v_o=1.

Function
- REQ-011: State SHALL be a 10-bit pending register P; IDLE when P==0, EMIT otherwise.
- REQ-012: ready_o SHALL equal (P==0); no new mask while emitting.
- REQ-013: On clk edge with v_i & ready_o, P SHALL load class_i[9:0].
- REQ-014: An accepted mask of all zeros (after ignoring 15:10) SHALL be dropped: no output, block stays IDLE.
- REQ-015: v_o SHALL equal (P!=0), driven from registers only; first v_o appears the cycle after acceptance (latency 1).
- REQ-016: class_o SHALL be the lowest set bit of P (one-hot), zero-extended to 16 bits; 0 when P==0.
- REQ-017: z_o SHALL map from class_o: bit0 -> 0xFC00, bit1 -> 0xBC00, bit2 -> 0x8001, bit3 -> 0x8000, bit4 -> 0x0000, bit5 -> 0x0001, bit6 -> 0x3C00, bit7 -> 0x7C00, bit8 -> 0x7C01 (sNaN), bit9 -> 0x7E00 (qNaN); 0x0000 when v_o=0.
- REQ-018: last_o SHALL be 1 when P has exactly one bit set, 0 otherwise.
- REQ-019: On clk edge with yumi_i & v_o, the lowest set bit of P SHALL be cleared; one value per cycle under continuous yumi_i.
- REQ-020: Outputs SHALL hold stable while v_o=1 and yumi_i=0.
- REQ-021: yumi_i while v_o=0 SHALL be ignored; v_i while ready_o=0 SHALL be ignored (mask not captured).
- REQ-022: Yumi of the last value returns P to 0; ready_o rises the next cycle, so the back-to-back accept gap is one cycle.
- REQ-023: Every emitted z_o, reclassified, SHALL yield exactly class_o.

Reset
- REQ-024: reset_i assertion SHALL clear P to 0 immediately, without waiting for a clock edge; this forces v_o=0, z_o=0x0000, class_o=0, last_o=0, ready_o=1.
- REQ-025: Reset mid-emission SHALL discard all remaining pending classes.
- REQ-026: The first accept SHALL occur no earlier than the first clk edge after reset_i deasserts.

Verification
- REQ-027: v_i=1, class_i=0x0081, yumi_i held 1 -> cycle+1: z_o=0xFC00, class_o=0x0001, last_o=0; cycle+2: z_o=0x7C00, class_o=0x0080, last_o=1; cycle+3: v_o=0, ready_o=1.
- REQ-028: class_i=0x0300, yumi_i=0 for 3 cycles then 1 -> z_o=0x7C01 held stable for 3 cycles, then 0x7E00 with last_o=1.
- REQ-029: class_i=0xFC00 (only ignored bits set) -> accepted, v_o stays 0, ready_o stays 1.
- REQ-030: class_i=0x03FF with continuous yumi_i -> 10 consecutive outputs 0xFC00, 0xBC00, 0x8001, 0x8000, 0x0000, 0x0001, 0x3C00, 0x7C00, 0x7C01, 0x7E00; last_o only on the 10th.
- REQ-031: reset_i pulsed between clk edges after 2 of 4 emissions of mask 0x00F0 -> v_o=0 and ready_o=1 at once; no remaining values appear.
- REQ-032: Random masks plus random yumi_i, with a scoreboard classifying each z_o -> the result matches class_o, and the emitted set equals the accepted mask bits 9:0.
